// File: rtl/serial_bitwise_pkg.sv
// serial_bitwise_pkg: opcode and FSM state encodings shared by the serial and parallel logic units.
`default_nettype none

package serial_bitwise_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_bitwise_unit_bit_logic_cell.sv
// bit_logic_cell: single-bit combinational logic function r = f(op, a, b).
`default_nettype none

module bit_logic_cell
  import serial_bitwise_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       r_o
);

  always_comb begin
    r_o = 1'b0;
    case (op_i)
      OP_AND:  r_o = a_i & b_i;
      OP_OR:   r_o = a_i | b_i;
      OP_XOR:  r_o = a_i ^ b_i;
      OP_NOR:  r_o = ~(a_i | b_i);
      default: r_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_bitwise_unit.sv
// serial_bitwise_unit: handshaked bit-serial AND/OR/XOR/NOR unit, one result bit per cycle, LSB first.
`default_nettype none

module serial_bitwise_unit
  import serial_bitwise_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_r;

  bit_logic_cell u_cell (
    .op_i (op_q),
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .r_o  (bit_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          op_d    = op;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        res_d = {bit_r, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Counter parks at its terminal value instead of wrapping; reloaded on accept.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_result = res_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_bitwise_unit.sv
// tb_serial_bitwise_unit: directed self-checking bench for WIDTH=4 and WIDTH=8 instances.
`default_nettype none

module tb_serial_bitwise_unit;

  logic       clk;
  logic       rst_n;

  logic       iv4, ir4, ov4, or4, busy4;
  logic [3:0] a4, b4, res4;
  logic [1:0] op4;

  logic       iv8, ir8, ov8, or8, busy8;
  logic [7:0] a8, b8, res8;
  logic [1:0] op8;

  int total;
  int bad;
  int lat;

  serial_bitwise_unit #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (iv4),
    .in_ready   (ir4),
    .in1        (a4),
    .in2        (b4),
    .op         (op4),
    .out_valid  (ov4),
    .out_ready  (or4),
    .out_result (res4),
    .busy       (busy4)
  );

  serial_bitwise_unit #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (iv8),
    .in_ready   (ir8),
    .in1        (a8),
    .in2        (b8),
    .op         (op8),
    .out_valid  (ov8),
    .out_ready  (or8),
    .out_result (res8),
    .busy       (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait4(output int n, input bit disturb);
    n = 0;
    do begin
      if (disturb) begin
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        op4 = 2'($urandom);
      end
      step();
      n++;
    end while (!ov4 && n < 40);
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ov8 && n < 40);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; op4 = '0; or4 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; or8 = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(ir4), 32'd1);
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_out_result", 32'(res4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_in_ready8", 32'(ir8), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // AND 0100 & 0011 = 0000
    iv4 = 1'b1; a4 = 4'b0100; b4 = 4'b0011; op4 = 2'b00; or4 = 1'b1;
    step();
    iv4 = 1'b0;
    chk("and_busy", 32'(busy4), 32'd1);
    chk("and_in_ready_shift", 32'(ir4), 32'd0);
    wait4(lat, 1'b0);
    chk("and_latency", 32'(lat), 32'd4);
    chk("and_result", 32'(res4), 32'h0);
    step();
    chk("and_in_ready_after", 32'(ir4), 32'd1);
    chk("and_valid_drop", 32'(ov4), 32'd0);

    // Back-to-back AND then OR, in_valid held high
    iv4 = 1'b1; a4 = 4'b0101; b4 = 4'b0101; op4 = 2'b00;
    step();
    a4 = 4'b1111; b4 = 4'b1000; op4 = 2'b01;
    wait4(lat, 1'b0);
    chk("b2b_and_latency", 32'(lat), 32'd4);
    chk("b2b_and_result", 32'(res4), 32'h5);
    chk("b2b_in_ready_done", 32'(ir4), 32'd0);
    step();
    chk("b2b_idle_in_ready", 32'(ir4), 32'd1);
    step();
    chk("b2b_second_accept", 32'(busy4), 32'd1);
    iv4 = 1'b0;
    wait4(lat, 1'b0);
    chk("b2b_or_latency", 32'(lat), 32'd4);
    chk("b2b_or_result", 32'(res4), 32'hF);
    step();

    // XOR with backpressure, NOR request waiting
    or4 = 1'b0;
    iv4 = 1'b1; a4 = 4'b1000; b4 = 4'b1111; op4 = 2'b10;
    step();
    a4 = 4'b1000; b4 = 4'b0011; op4 = 2'b11;
    wait4(lat, 1'b0);
    chk("xor_result", 32'(res4), 32'h7);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", 32'(ov4), 32'd1);
      chk("bp_result_hold", 32'(res4), 32'h7);
      chk("bp_in_ready_low", 32'(ir4), 32'd0);
    end
    or4 = 1'b1;
    step();
    chk("bp_handshake_valid", 32'(ov4), 32'd0);
    chk("bp_handshake_idle", 32'(busy4), 32'd0);
    step();
    chk("nor_accept", 32'(busy4), 32'd1);
    iv4 = 1'b0;
    wait4(lat, 1'b0);
    chk("nor_latency", 32'(lat), 32'd4);
    chk("nor_result", 32'(res4), 32'h4);
    step();

    // Operand disturbance during SHIFT: 1100 ^ 1010 = 0110
    iv4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010; op4 = 2'b10;
    step();
    iv4 = 1'b0;
    wait4(lat, 1'b1);
    chk("dist_latency", 32'(lat), 32'd4);
    chk("dist_result", 32'(res4), 32'h6);
    step();

    // Asynchronous reset two cycles into SHIFT
    iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; op4 = 2'b01;
    step();
    iv4 = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov4), 32'd0);
    chk("arst_in_ready", 32'(ir4), 32'd1);
    chk("arst_busy", 32'(busy4), 32'd0);
    chk("arst_result", 32'(res4), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    iv4 = 1'b1; a4 = 4'b1000; b4 = 4'b1111; op4 = 2'b00;
    step();
    iv4 = 1'b0;
    wait4(lat, 1'b0);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_result", 32'(res4), 32'h8);
    step();

    // WIDTH=8: A5 & 0F = 05
    iv8 = 1'b1; a8 = 8'hA5; b8 = 8'h0F; op8 = 2'b00; or8 = 1'b1;
    step();
    iv8 = 1'b0;
    wait8(lat);
    chk("w8_latency", 32'(lat), 32'd8);
    chk("w8_result", 32'(res8), 32'h05);
    chk("w8_cnt_terminal", 32'(dut8.cnt_q), 32'd7);
    step();
    chk("w8_in_ready", 32'(ir8), 32'd1);
    chk("w8_cnt_no_wrap", 32'(dut8.cnt_q), 32'd7);
    iv8 = 1'b1; a8 = 8'h80; b8 = 8'h01; op8 = 2'b01;
    step();
    iv8 = 1'b0;
    chk("w8_cnt_reload", 32'(dut8.cnt_q), 32'd0);
    wait8(lat);
    chk("w8_or_latency", 32'(lat), 32'd8);
    chk("w8_or_result", 32'(res8), 32'h81);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
